alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared by two requesters with round-robin arbitration
// IDLE latches the winner's operands, EXEC computes, RESP pulses that requester's ack.
module alu_share_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reqA_i,
  input  logic        reqB_i,
  input  logic [31:0] src1A_i,
  input  logic [31:0] src2A_i,
  input  logic [31:0] src1B_i,
  input  logic [31:0] src2B_i,
  input  logic [3:0]  ctrlA_i,
  input  logic [3:0]  ctrlB_i,
  output logic        ackA_o,
  output logic        ackB_o,
  output logic [31:0] resultA_o,
  output logic [31:0] resultB_o,
  output logic        zeroA_o,
  output logic        zeroB_o,
  output logic        busy_o,
  output logic        grant_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t      r_state;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [3:0]  r_ctrl;
  logic        r_prio_b;
  logic        r_grant;
  logic        r_ackA;
  logic        r_ackB;
  logic        r_busy;
  logic [31:0] r_resA;
  logic [31:0] r_resB;
  logic        r_zeroA;
  logic        r_zeroB;

  logic [31:0] w_alu;
  logic        w_pick_b;

  // B wins when alone, or when both request and B holds the round-robin priority.
  assign w_pick_b = reqB_i & (~reqA_i | r_prio_b);

  always_comb begin
    w_alu = 32'h0000_0000;
    case (r_ctrl)
      4'b0000: w_alu = r_op1 & r_op2;
      4'b0001: w_alu = r_op1 | r_op2;
      4'b0010: w_alu = r_op1 + r_op2;
      4'b0110: w_alu = r_op1 - r_op2;
      4'b0111: w_alu = {31'b0, ($signed(r_op1) < $signed(r_op2))};
      default: w_alu = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_op1    <= 32'h0000_0000;
      r_op2    <= 32'h0000_0000;
      r_ctrl   <= 4'b0000;
      r_prio_b <= 1'b0;
      r_grant  <= 1'b0;
      r_ackA   <= 1'b0;
      r_ackB   <= 1'b0;
      r_busy   <= 1'b0;
      r_resA   <= 32'h0000_0000;
      r_resB   <= 32'h0000_0000;
      r_zeroA  <= 1'b1;
      r_zeroB  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ackA <= 1'b0;
          r_ackB <= 1'b0;
          if (reqA_i || reqB_i) begin
            r_op1    <= w_pick_b ? src1B_i : src1A_i;
            r_op2    <= w_pick_b ? src2B_i : src2A_i;
            r_ctrl   <= w_pick_b ? ctrlB_i : ctrlA_i;
            r_grant  <= w_pick_b;
            r_prio_b <= ~w_pick_b;
            r_busy   <= 1'b1;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_grant) begin
            r_resB  <= w_alu;
            r_zeroB <= (w_alu == 32'h0000_0000);
            r_ackB  <= 1'b1;
          end else begin
            r_resA  <= w_alu;
            r_zeroA <= (w_alu == 32'h0000_0000);
            r_ackA  <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_ackA  <= 1'b0;
          r_ackB  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ackA_o    = r_ackA;
  assign ackB_o    = r_ackB;
  assign resultA_o = r_resA;
  assign resultB_o = r_resB;
  assign zeroA_o   = r_zeroA;
  assign zeroB_o   = r_zeroB;
  assign busy_o    = r_busy;
  assign grant_o   = r_grant;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and random operations against a transaction-level model
module tb_alu_share_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        reqA_i = 1'b0, reqB_i = 1'b0;
  logic [31:0] src1A_i = '0, src2A_i = '0, src1B_i = '0, src2B_i = '0;
  logic [3:0]  ctrlA_i = '0, ctrlB_i = '0;
  logic        ackA_o, ackB_o, zeroA_o, zeroB_o, busy_o, grant_o;
  logic [31:0] resultA_o, resultB_o;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last_ack_cyc = 0;

  logic [31:0] m_res [2];
  logic        m_prio_b;

  alu_share_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reqA_i(reqA_i), .reqB_i(reqB_i),
    .src1A_i(src1A_i), .src2A_i(src2A_i), .src1B_i(src1B_i), .src2B_i(src2B_i),
    .ctrlA_i(ctrlA_i), .ctrlB_i(ctrlB_i),
    .ackA_o(ackA_o), .ackB_o(ackB_o),
    .resultA_o(resultA_o), .resultB_o(resultB_o),
    .zeroA_o(zeroA_o), .zeroB_o(zeroB_o),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      4'b0110: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_resA"}, resultA_o, m_res[0]);
    check({tag, "_resB"}, resultB_o, m_res[1]);
    check({tag, "_zeroA"}, {31'b0, zeroA_o}, {31'b0, m_res[0] == 32'd0});
    check({tag, "_zeroB"}, {31'b0, zeroB_o}, {31'b0, m_res[1] == 32'd0});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    reqA_i = 1'b0;
    reqB_i = 1'b0;
    repeat (2) @(negedge clk_i);
    m_res[0] = 32'd0;
    m_res[1] = 32'd0;
    m_prio_b = 1'b0;
    check("rst_ack", {30'b0, ackA_o, ackB_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_grant", {31'b0, grant_o}, 32'd0);
    check_results("rst");
    rst_i = 1'b1;
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the following idle cycle.
  task automatic run_op(input string tag, input logic ra, input logic rb,
                        input logic [3:0] ca, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [3:0] cb, input logic [31:0] b1, input logic [31:0] b2,
                        input logic keep);
    logic        w;
    logic [31:0] exp;
    int          n;
    reqA_i = ra; ctrlA_i = ca; src1A_i = a1; src2A_i = a2;
    reqB_i = rb; ctrlB_i = cb; src1B_i = b1; src2B_i = b2;
    w = (ra && rb) ? m_prio_b : rb;
    exp = w ? alu_ref(cb, b1, b2) : alu_ref(ca, a1, a2);
    m_prio_b = ~w;
    @(posedge clk_i); @(negedge clk_i);
    check({tag, "_exec_busy"}, {31'b0, busy_o}, 32'd1);
    check({tag, "_exec_noack"}, {30'b0, ackA_o, ackB_o}, 32'd0);
    if (w) begin
      src1B_i = $urandom; src2B_i = $urandom; ctrlB_i = 4'($urandom);
      if (!keep && $urandom_range(0, 1) == 1) reqB_i = 1'b0;
    end else begin
      src1A_i = $urandom; src2A_i = $urandom; ctrlA_i = 4'($urandom);
      if (!keep && $urandom_range(0, 1) == 1) reqA_i = 1'b0;
    end
    n = 1;
    while (!(ackA_o || ackB_o) && n < 6) begin
      @(posedge clk_i); @(negedge clk_i);
      n++;
    end
    last_ack_cyc = cyc;
    check({tag, "_latency"}, n, 32'd2);
    check({tag, "_acks"}, {30'b0, ackA_o, ackB_o}, w ? 32'd1 : 32'd2);
    check({tag, "_grant"}, {31'b0, grant_o}, {31'b0, w});
    m_res[w] = exp;
    check_results(tag);
    if (!keep) begin
      if (w) reqB_i = 1'b0;
      else reqA_i = 1'b0;
    end
    @(posedge clk_i); @(negedge clk_i);
    check({tag, "_idle_noack"}, {29'b0, ackA_o, ackB_o, busy_o}, 32'd0);
    check({tag, "_stable_res"}, w ? resultB_o : resultA_o, exp);
  endtask

  initial begin
    int t0;
    logic [3:0] ops [5];
    logic [3:0] c1, c2;
    logic ra, rb;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};

    do_reset();

    @(negedge clk_i);
    run_op("single_add", 1, 0, 4'b0010, 32'd7, 32'd5, 4'b0, 32'd0, 32'd0, 0);

    do_reset();
    run_op("cont_a", 1, 1, 4'b0110, 32'd9, 32'd9, 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    t0 = last_ack_cyc;
    run_op("cont_b", 0, 1, 4'b0110, 32'd9, 32'd9, 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
    check("cont_spacing", last_ack_cyc - t0, 32'd3);

    run_op("add_wrap", 1, 0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'b0, 32'd0, 32'd0, 0);
    run_op("undef_b", 0, 1, 4'b0, 32'd0, 32'd0, 4'b1111, 32'h1234_5678, 32'h9, 0);
    run_op("or_b", 0, 1, 4'b0, 32'd0, 32'd0, 4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, 0);
    run_op("undef_b2", 0, 1, 4'b0, 32'd0, 32'd0, 4'b1010, 32'h5, 32'h6, 0);
    run_op("and_hold", 1, 0, 4'b0000, 32'd3, 32'd1, 4'b0, 32'd0, 32'd0, 0);

    for (int i = 0; i < 4; i++)
      run_op("fair", 1, 1, 4'b0010, i, 32'd100, 4'b0110, 32'd50, i, 1);

    for (int i = 0; i < 30; i++) begin
      ra = 1'($urandom);
      rb = 1'($urandom);
      if (!ra && !rb) ra = 1'b1;
      c1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
      c2 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
      run_op("rand", ra, rb, c1, $urandom, (i % 5 == 0) ? 32'd0 : $urandom,
             c2, $urandom, (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom, 1'($urandom));
    end

    reqA_i = 1'b0; reqB_i = 1'b0;
    @(negedge clk_i);
    reqA_i = 1'b1; ctrlA_i = 4'b0010; src1A_i = 32'd40; src2A_i = 32'd2;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    reqA_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    m_res[0] = 32'd0;
    m_res[1] = 32'd0;
    m_prio_b = 1'b0;
    check("midrst_ack", {30'b0, ackA_o, ackB_o}, 32'd0);
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    check_results("midrst");
    rst_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); @(negedge clk_i);
      check("midrst_after", {29'b0, ackA_o, ackB_o, busy_o}, 32'd0);
    end
    run_op("post_rst", 1, 1, 4'b0001, 32'h0F, 32'hF0, 4'b0010, 32'd1, 32'd1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
